// File: rtl/cdc_4phase_src_arbiter.sv
// rtl/cdc_4phase_src_arbiter.sv - round-robin arbiter feeding one 4-phase CDC source
//
// Shares a single cdc_4phase_src valid/ready input between NUM_REQ local
// requesters. The winning message is registered and held until the CDC
// accepts it. A sticky watchdog flags a CDC that stops accepting.
//
// Ports:
//   clk_i        source-domain clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester message valid
//   req_data_i   per-requester message
//   req_ready_o  per-requester accept (one-hot or zero, combinational)
//   cdc_data_o   held message towards the CDC source
//   cdc_valid_o  held message valid towards the CDC source
//   cdc_ready_i  CDC source accept
//   grant_idx_o  index of the requester whose message is held
//   busy_o       a message is held
//   timeout_o    sticky watchdog flag

package cdc_reset_ctrlr_pkg;
  typedef enum logic [1:0] {
    CLEAR_PHASE_IDLE       = 2'd0,
    CLEAR_PHASE_ISOLATE    = 2'd1,
    CLEAR_PHASE_CLEAR      = 2'd2,
    CLEAR_PHASE_POST_CLEAR = 2'd3
  } clear_seq_phase_e;
endpackage

module cdc_4phase_src_arbiter
  import cdc_reset_ctrlr_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic             [NUM_REQ-1:0] req_valid_i,
  input  clear_seq_phase_e [NUM_REQ-1:0] req_data_i,
  output logic             [NUM_REQ-1:0] req_ready_o,
  output clear_seq_phase_e               cdc_data_o,
  output logic                           cdc_valid_o,
  input  logic                           cdc_ready_i,
  output logic             [IDX_W-1:0]   grant_idx_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [15:0]      TMO       = 16'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  clear_seq_phase_e data_q, data_d;
  logic [15:0]      stall_q, stall_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;

  // Round-robin search starting at prio_q. The candidate is formed one bit
  // wider so the modulo wrap works for non-power-of-two NUM_REQ.
  always_comb begin : search
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, prio_q} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && req_valid_i[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin : fsm
    state_d     = state_q;
    prio_d      = prio_q;
    idx_d       = idx_q;
    data_d      = data_q;
    stall_d     = stall_q;
    timeout_d   = timeout_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready_o[win_idx] = 1'b1;
          data_d               = req_data_i[win_idx];
          idx_d                = win_idx;
          state_d              = HOLD;
        end
      end
      HOLD: begin
        if (cdc_ready_i) begin
          // Pointer advances only once the CDC has taken the message.
          prio_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          stall_d = '0;
          state_d = IDLE;
        end else if (TMO != 16'd0 && stall_q != TMO) begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Set on the edge that completes the TMO-th stall cycle.
    if (TMO != 16'd0 && stall_d == TMO) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      prio_q    <= '0;
      idx_q     <= '0;
      data_q    <= CLEAR_PHASE_IDLE;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign cdc_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q == HOLD);
  assign cdc_data_o  = data_q;
  assign grant_idx_o = idx_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cdc_4phase_src_arbiter.sv
// tb/tb_cdc_4phase_src_arbiter.sv - directed bench for cdc_4phase_src_arbiter
module tb_cdc_4phase_src_arbiter;
  import cdc_reset_ctrlr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-requester instance with an 8-cycle watchdog
  logic             [3:0] v4, rdy4;
  clear_seq_phase_e [3:0] d4;
  clear_seq_phase_e       q4;
  logic                   val4, cr4, busy4, to4;
  logic             [1:0] g4;

  // 3-requester instance, watchdog disabled
  logic             [2:0] v3, rdy3;
  clear_seq_phase_e [2:0] d3;
  clear_seq_phase_e       q3;
  logic                   val3, cr3, busy3, to3;
  logic             [1:0] g3;

  int errors = 0;
  int checks = 0;

  cdc_4phase_src_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v4), .req_data_i(d4),
    .req_ready_o(rdy4), .cdc_data_o(q4), .cdc_valid_o(val4),
    .cdc_ready_i(cr4), .grant_idx_o(g4), .busy_o(busy4), .timeout_o(to4)
  );

  cdc_4phase_src_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(0)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v3), .req_data_i(d3),
    .req_ready_o(rdy3), .cdc_data_o(q3), .cdc_valid_o(val3),
    .cdc_ready_i(cr3), .grant_idx_o(g3), .busy_o(busy3), .timeout_o(to3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v4  = '0;
    v3  = '0;
    cr4 = 1'b1;
    cr3 = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v4  = '0;
    v3  = '0;
    cr4 = 1'b1;
    cr3 = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = CLEAR_PHASE_IDLE;
    for (int i = 0; i < 3; i++) d3[i] = CLEAR_PHASE_IDLE;
    step();
    step();
    settle();
    check("rst_valid",   val4, 0);
    check("rst_ready",   rdy4, 0);
    check("rst_busy",    busy4, 0);
    check("rst_timeout", to4, 0);
    check("rst_grant",   g4, 0);
    check("rst_data",    q4, CLEAR_PHASE_IDLE);
    rst = 1'b0;

    // Non-power-of-two wrap on the 3-requester instance
    v3 = 3'b100;
    d3[2] = CLEAR_PHASE_POST_CLEAR;
    settle();
    check("n3_ready_r2", rdy3, 3'b100);
    step();
    v3 = 3'b101;
    d3[0] = CLEAR_PHASE_ISOLATE;
    d3[2] = CLEAR_PHASE_CLEAR;
    settle();
    check("n3_valid", val3, 1);
    check("n3_grant2", g3, 2);
    check("n3_data2", q3, CLEAR_PHASE_POST_CLEAR);
    check("n3_hold_ready", rdy3, 0);
    step();
    settle();
    check("n3_idle_valid", val3, 0);
    check("n3_wrap_ready", rdy3, 3'b001);
    step();
    v3 = 3'b100;
    settle();
    check("n3_grant0", g3, 0);
    check("n3_data0", q3, CLEAR_PHASE_ISOLATE);
    step();
    v3 = 3'b101;
    settle();
    check("n3_after0_ready", rdy3, 3'b100);
    step();
    v3 = 3'b000;
    settle();
    check("n3_grant2b", g3, 2);
    check("n3_data2b", q3, CLEAR_PHASE_CLEAR);
    step();

    // Single request on the 4-requester instance
    do_reset();
    v4 = 4'b0100;
    d4[2] = CLEAR_PHASE_CLEAR;
    settle();
    check("single_ready", rdy4, 4'b0100);
    step();
    v4 = 4'b0000;
    settle();
    check("single_valid", val4, 1);
    check("single_data",  q4, CLEAR_PHASE_CLEAR);
    check("single_grant", g4, 2);
    check("single_busy",  busy4, 1);
    check("single_hold_ready", rdy4, 0);
    step();
    v4 = 4'b1011;
    settle();
    check("single_idle_valid", val4, 0);
    check("single_idle_busy",  busy4, 0);
    check("single_prio3", rdy4, 4'b1000);
    v4 = 4'b0000;

    // Full contention: grants 0,1,2,3,0,1 at one per two cycles
    do_reset();
    for (int i = 0; i < 4; i++) d4[i] = clear_seq_phase_e'(2'(i));
    v4 = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      settle();
      check("rr_ready", rdy4, 32'(1 << (g % 4)));
      check("rr_idle_valid", val4, 0);
      step();
      settle();
      check("rr_valid", val4, 1);
      check("rr_grant", g4, 32'(g % 4));
      check("rr_data",  q4, 32'(g % 4));
      check("rr_hold_ready", rdy4, 0);
      step();
    end
    v4 = 4'b0000;

    // Back-pressure for 20 cycles with an 8-cycle watchdog
    do_reset();
    cr4 = 1'b0;
    v4 = 4'b0001;
    d4[0] = CLEAR_PHASE_ISOLATE;
    step();
    v4 = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      settle();
      check("bp_valid", val4, 1);
      check("bp_data",  q4, CLEAR_PHASE_ISOLATE);
      check("bp_grant", g4, 0);
      check("bp_timeout", to4, (c >= 9) ? 1 : 0);
      step();
    end
    cr4 = 1'b1;
    settle();
    check("bp_deliver_valid", val4, 1);
    check("bp_deliver_data",  q4, CLEAR_PHASE_ISOLATE);
    step();
    settle();
    check("bp_done_valid", val4, 0);
    check("bp_sticky_timeout", to4, 1);

    // Reset while holding a message
    do_reset();
    cr4 = 1'b0;
    v4 = 4'b0010;
    d4[1] = CLEAR_PHASE_POST_CLEAR;
    step();
    v4 = 4'b0000;
    repeat (10) step();
    settle();
    check("mid_timeout_pre", to4, 1);
    check("mid_grant_pre", g4, 1);
    check("mid_valid_pre", val4, 1);
    rst = 1'b1;
    step();
    settle();
    check("mid_valid", val4, 0);
    check("mid_busy", busy4, 0);
    check("mid_timeout", to4, 0);
    check("mid_grant", g4, 0);
    rst = 1'b0;
    cr4 = 1'b1;
    v4 = 4'b1111;
    settle();
    check("mid_next_from0", rdy4, 4'b0001);
    v4 = 4'b0000;
    step();
    step();

    // Valid withdrawn before the handshake
    do_reset();
    cr4 = 1'b0;
    v4 = 4'b0001;
    d4[0] = CLEAR_PHASE_CLEAR;
    step();
    v4 = 4'b0010;
    repeat (3) begin
      settle();
      check("wd_hold_ready", rdy4, 0);
      check("wd_hold_grant", g4, 0);
      step();
    end
    v4 = 4'b0000;
    cr4 = 1'b1;
    step();
    repeat (4) begin
      settle();
      check("wd_no_valid", val4, 0);
      check("wd_no_busy", busy4, 0);
      check("wd_no_ready", rdy4, 0);
      check("wd_grant", g4, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_4phase_src_arbiter.md
# cdc_4phase_src_arbiter

Round-robin arbiter sharing one 4-phase CDC source half between `NUM_REQ` local requesters of `cdc_reset_ctrlr_pkg::clear_seq_phase_e` messages. Sits in the source clock domain, directly in front of the `cdc_4phase_src` valid/ready input. Each winning message is captured into an output register and held stable until the CDC accepts it. A sticky watchdog flags a CDC that stops accepting messages.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `TIMEOUT_CYCLES`, default 0: stall cycles before `timeout_o` asserts; 0 disables the watchdog; legal range 0..65535.
- `IDX_W`, default `$clog2(NUM_REQ)`: derived; width of `grant_idx_o`; not to be overridden.

Ports:
- `clk_i`  in  1  source-domain clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  `NUM_REQ`  per-requester message valid.
- `req_data_i`  in  `NUM_REQ` x `clear_seq_phase_e`  per-requester message.
- `req_ready_o`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `cdc_data_o`  out  `clear_seq_phase_e`  message to the CDC source `data_i`.
- `cdc_valid_o`  out  1  to the CDC source `valid_i`.
- `cdc_ready_i`  in  1  from the CDC source `ready_o`.
- `grant_idx_o`  out  `IDX_W`  index of the requester whose message is held.
- `busy_o`  out  1  high while a message is held (state HOLD).
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
The controller has two states, IDLE and HOLD.

IDLE:
- `cdc_valid_o`=0.
- Winner = first index i with `req_valid_i[i]`=1, searching from `prio_q` upward and wrapping modulo `NUM_REQ`.
- If a winner exists:
  - `req_ready_o[winner]`=1 combinationally in the same cycle.
  - `req_data_i[winner]` is captured into `data_q`; winner is captured into `idx_q`.
  - Next state is HOLD.
- If no winner exists: `req_ready_o`=0 and the state stays IDLE.

HOLD:
- `req_ready_o`=0.
- `cdc_valid_o`=1, `cdc_data_o`=`data_q`, `grant_idx_o`=`idx_q`, `busy_o`=1.
- On `cdc_ready_i`=1:
  - the transfer completes;
  - `prio_q` <= (`idx_q`+1) mod `NUM_REQ`, which needs explicit wrap logic when `NUM_REQ` is not a power of two;
  - next state is IDLE.
- Otherwise the state stays HOLD and the held outputs stay bit-stable.

Fairness and ordering:
- The priority pointer moves only on a completed CDC handshake, never on acceptance alone.
- With all requesters continuously valid, the grant order is 0, 1, ..., N-1, 0, ...
- The arbiter does not change the message value, reorder messages from one requester, or merge messages.

Requester rules:
- `req_valid_i` must not depend combinationally on `req_ready_o`.
- A requester holds valid and data until it sees ready.
- A requester may drop valid before it is granted; the arbiter does not treat this as an error.

Watchdog:
- 16-bit counter `stall_q`.
- Counts cycles in HOLD with `cdc_ready_i`=0 and clears on the handshake.
- When `TIMEOUT_CYCLES`≠0 and `stall_q` reaches `TIMEOUT_CYCLES`, `timeout_o` <= 1.
- `timeout_o` stays at 1 until `rst_i`.
- The counter saturates at `TIMEOUT_CYCLES`.
- The watchdog never aborts or drops the held message.

Reset:
- State IDLE, `prio_q`=0, `data_q`=`CLEAR_PHASE_IDLE`, `idx_q`=0, `stall_q`=0.
- Outputs: `cdc_valid_o`=0, `req_ready_o`=0, `busy_o`=0, `timeout_o`=0, `grant_idx_o`=0.

Reset mid-operation:
- A held message is discarded; the requester has already seen ready, so the message is lost by design.
- `cdc_valid_o` is 0 in the cycle after `rst_i` is sampled high.

## Timing
- Acceptance at edge t, meaning `req_valid_i[i]` & `req_ready_o[i]` are both 1 in the cycle before edge t.
- `cdc_valid_o` rises in the cycle after t, i.e. a latency of 1 cycle.
- The CDC handshake completes at edge t+1+k, where k is the number of cycles `cdc_ready_i` is low.
- IDLE then follows for at least one cycle. Minimum spacing between acceptances is therefore 2 cycles, i.e. throughput of 1 message per 2 cycles.
- `cdc_valid_o`, `cdc_data_o`, `grant_idx_o` and `busy_o` are registered with no combinational path from any input.
- `req_ready_o` is combinational from `req_valid_i`, state and `prio_q`.
- `timeout_o` asserts in the cycle after the `TIMEOUT_CYCLES`-th consecutive stall cycle.
- Simultaneous events:
  - A new `req_valid_i` arriving in the same cycle as a handshake is not accepted until the following IDLE cycle.
  - `rst_i` overrides every other event in the same cycle.

## Test plan
- **Single request:** reset; `req_valid_i`=4'b0100 with data `CLEAR_PHASE_CLEAR`, `cdc_ready_i`=1 → `req_ready_o`=4'b0100 in that cycle; next cycle `cdc_valid_o`=1, data=`CLEAR_PHASE_CLEAR`, `grant_idx_o`=2; afterwards `prio_q`=3.
- **Full contention:** all 4 requesters valid continuously, `cdc_ready_i`=1 → grants 0,1,2,3,0,1; one accept every 2 cycles; no requester starved.
- **Back-pressure and hold:** hold `cdc_ready_i`=0 for 20 cycles with `TIMEOUT_CYCLES`=8 → `cdc_data_o` and `grant_idx_o` stable for all 20 cycles; `timeout_o` rises after 8 stall cycles and stays 1 after `cdc_ready_i` returns to 1; the message is still delivered.
- **Non-power-of-two wrap:** `NUM_REQ`=3; requester 2 granted and handshaked, then requesters 0 and 2 both valid → grant 0; `prio_q` never reaches 3.
- **Reset mid-HOLD:** assert `rst_i` for 1 cycle while in HOLD → next cycle `cdc_valid_o`=0, `busy_o`=0, `timeout_o`=0, `grant_idx_o`=0; the next grant starts from index 0.
- **Valid withdrawn:** requester 1 raises valid while requester 0 is held, then drops it before the handshake → requester 1 is never granted; no spurious `cdc_valid_o` occurs.
